// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants, state type and round-robin search helper for
//            the 16-requester arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set request at or after ptr, searching upward with wrap 15->0.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] k;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr + IDX_W'(i);
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_2_4.sv
`default_nettype none
// ============================================================================
// Module   : dec_2_4
// Purpose  : 2-to-4 one-hot decoder with enable.
// Revision : 1.0 - initial release
// ============================================================================
module dec_2_4 (
  input  logic [1:0] a,
  input  logic       en,
  output logic [3:0] y
);

  // One-hot decode, all zeros while disabled
  always_comb begin
    y    = 4'b0000;
    y[a] = en;
  end

endmodule
`default_nettype wire

// File: rtl/dec_4_16.sv
`default_nettype none
// ============================================================================
// Module   : dec_4_16
// Purpose  : 4-to-16 one-hot decoder with enable, built from dec_2_4 stages.
// Revision : 1.0 - initial release
// ============================================================================
module dec_4_16 (
  input  logic [3:0]  a,
  input  logic        en,
  output logic [15:0] y
);

  logic [3:0] w_grp_en;

  // Upper two bits pick which low-order decoder is enabled
  dec_2_4 u_hi (
    .a  (a[3:2]),
    .en (en),
    .y  (w_grp_en)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_low
      dec_2_4 u_lo (
        .a  (a[1:0]),
        .en (w_grp_en[g]),
        .y  (y[4*g +: 4])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rr_arb_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_16
// Purpose  : Round-robin arbiter for 16 requesters. A grant is held until the
//            grantee signals done, drops its request, or reaches HOLD_MAX
//            cycles; every release is followed by one dead GAP cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  // A zero HOLD_MAX still needs a 1-bit counter so the logic stays legal
  localparam int c_hc_w = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [c_hc_w-1:0] c_hold_max = c_hc_w'(HOLD_MAX);
  localparam logic [c_hc_w-1:0] c_hold_one = c_hc_w'(1);

  arb_state_t        r_state,    w_state_nxt;
  logic [IDX_W-1:0]  r_ptr,      w_ptr_nxt;
  logic [IDX_W-1:0]  r_gnt_idx,  w_gnt_idx_nxt;
  logic              r_gnt_vld,  w_gnt_vld_nxt;
  logic [c_hc_w-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_timeout,  w_timeout_nxt;

  pick_t             w_pick;
  logic              w_req_held;
  logic              w_limit;

  // Registered arbiter state; everything returns to zero on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state: pick in IDLE, hold or release in GRANT, one dead cycle in GAP
  always_comb begin
    w_pick         = rr_pick(req, r_ptr);
    w_req_held     = req[r_gnt_idx];
    w_limit        = (HOLD_MAX != 0) && (r_hold_cnt == c_hold_max);
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_gnt_idx_nxt  = w_pick.idx;
          w_gnt_vld_nxt  = 1'b1;
          w_hold_cnt_nxt = c_hold_one;
          w_state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (done || !w_req_held || w_limit) begin
          // Timeout only when the limit alone caused the release
          w_timeout_nxt  = !done && w_req_held;
          w_gnt_vld_nxt  = 1'b0;
          w_ptr_nxt      = r_gnt_idx + IDX_W'(1);
          w_hold_cnt_nxt = '0;
          w_state_nxt    = GAP;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_gnt_vld_nxt = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers; gnt only passes through the decoder
  always_comb begin
    gnt_idx = r_gnt_idx;
    gnt_vld = r_gnt_vld;
    timeout = r_timeout;
  end

  dec_4_16 u_dec (
    .a  (r_gnt_idx),
    .en (r_gnt_vld),
    .y  (gnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_16
// Purpose  : Self-checking bench for rr_arb_16 (HOLD_MAX = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_16 #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        to;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] e_gnt,
                           input logic [3:0] e_idx, input logic e_vld, input logic e_to);
    check({name, ".gnt"},     32'(gnt),     32'(e_gnt));
    check({name, ".gnt_idx"}, 32'(gnt_idx), 32'(e_idx));
    check({name, ".gnt_vld"}, 32'(gnt_vld), 32'(e_vld));
    check({name, ".timeout"}, 32'(timeout), 32'(e_to));
  endtask

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Each row: inputs applied before an edge, outputs expected after it
    vecs[0]  = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'hFFFF, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'hFFFF, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0020, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 16'h0020, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h0020, 1'b1, 16'h0000, 4'd5, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    #1;

    // Reset, first grant, single-request hold and done release
    for (int v = 0; v < 12; v++) begin
      rst_n = vecs[v].rst_n;
      req   = vecs[v].req;
      done  = vecs[v].done;
      tick();
      check_out($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].vld, vecs[v].to);
    end

    // Rotation: all requesting, done on first grant cycle, two idle cycles between
    do_reset();
    req = 16'hFFFF;
    tick();
    for (int k = 0; k < 17; k++) begin
      check($sformatf("rot%0d.idx", k), 32'(gnt_idx), 32'(k % 16));
      check($sformatf("rot%0d.gnt", k), 32'(gnt), 32'(1) << (k % 16));
      done = 1'b1;
      tick();
      done = 1'b0;
      check($sformatf("rot%0d.gap", k), 32'(gnt_vld), 32'(0));
      tick();
      check($sformatf("rot%0d.idle", k), 32'(gnt_vld), 32'(0));
      tick();
    end
    done = 1'b0;

    // Wrap: after idx 14 the search from 15 wraps to 0, then 1
    do_reset();
    req = 16'h4000;
    tick();
    check_out("wrap14", 16'h4000, 4'd14, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0003;
    tick();
    tick();
    check_out("wrap0", 16'h0001, 4'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    tick();
    check_out("wrap1", 16'h0002, 4'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Timeout: idx 3 held for 8 cycles, one-cycle timeout pulse, then idx 7
    do_reset();
    req = 16'h0088;
    tick();
    check_out("to_c1", 16'h0008, 4'd3, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check_out($sformatf("to_c%0d", c), 16'h0008, 4'd3, 1'b1, 1'b0);
    end
    tick();
    check_out("to_gap", 16'h0000, 4'd3, 1'b0, 1'b1);
    tick();
    check_out("to_idle", 16'h0000, 4'd3, 1'b0, 1'b0);
    tick();
    check_out("to_next", 16'h0080, 4'd7, 1'b1, 1'b0);
    // Done in the 8th cycle wins over the limit
    for (int c = 2; c <= 8; c++) begin
      tick();
      check($sformatf("dn_c%0d.vld", c), 32'(gnt_vld), 32'(1));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check_out("dn_gap", 16'h0000, 4'd7, 1'b0, 1'b0);

    // Drop: req[9] falls in the 3rd grant cycle, pointer moves to 10
    do_reset();
    req = 16'h0200;
    tick();
    tick();
    tick();
    check_out("drop_c3", 16'h0200, 4'd9, 1'b1, 1'b0);
    req = 16'h0000;
    tick();
    check_out("drop_gap", 16'h0000, 4'd9, 1'b0, 1'b0);
    req = 16'h0600;
    tick();
    tick();
    check_out("drop_ptr", 16'h0400, 4'd10, 1'b1, 1'b0);

    // Reset mid-grant clears outputs and pointer
    rst_n = 1'b0;
    tick();
    check_out("rst_mid", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 16'hFFFF;
    tick();
    check_out("rst_restart", 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
